// File: rtl/z_raster_scheduler.sv
// rtl/z_raster_scheduler.sv - barycentric Z raster scheduler for one triangle at a time
//
// Purpose:
//   Accepts one screen-space triangle and walks its bounding box row-major.
//   For every pixel it forms the three doubled sub-triangle areas and tests
//   whether they sum to the doubled triangle area (edges and vertices count
//   as inside). Each inside pixel gets its depth from one shared restoring
//   divider, num / A, and is streamed out on a valid/ready handshake.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   tri_valid / tri_ready   triangle handshake (tri_ready only in IDLE, not on done cycle)
//   px,py,qx,qy,rx,ry       vertex screen coordinates, unsigned COORD_W
//   pz,qz,rz                vertex depths, Z_W
//   out_valid / out_ready   pixel handshake
//   out_x,out_y,out_z       pixel coordinates and interpolated depth
//   done                    one-cycle pulse when a triangle is finished
//   busy                    high whenever the FSM is not in IDLE

module z_raster_scheduler #(
  parameter int COORD_W = 10,
  parameter int Z_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tri_valid,
  output logic               tri_ready,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  input  logic [COORD_W-1:0] qx,
  input  logic [COORD_W-1:0] qy,
  input  logic [COORD_W-1:0] rx,
  input  logic [COORD_W-1:0] ry,
  input  logic [Z_W-1:0]     pz,
  input  logic [Z_W-1:0]     qz,
  input  logic [Z_W-1:0]     rz,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic [Z_W-1:0]     out_z,
  output logic               done,
  output logic               busy
);

  // Signed shoelace intermediate, its magnitude, the three-area sum and the
  // depth-weighted numerator.
  localparam int S_W    = 2*COORD_W + 3;
  localparam int AREA_W = S_W - 1;
  localparam int SUM_W  = AREA_W + 2;
  localparam int NUM_W  = Z_W + AREA_W + 2;
  localparam int CNT_W  = $clog2(Z_W) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SCAN,
    S_DIVIDE,
    S_EMIT
  } state_t;

  state_t r_state;
  state_t w_next;

  // Latched triangle
  logic [COORD_W-1:0] r_px, r_py, r_qx, r_qy, r_rx, r_ry;
  logic [Z_W-1:0]     r_pz, r_qz, r_rz;

  // Scan bookkeeping
  logic [AREA_W-1:0]  r_area;
  logic [COORD_W-1:0] r_xmin, r_xmax, r_ymin, r_ymax;
  logic [COORD_W-1:0] r_cx, r_cy;

  // Divider
  logic [NUM_W-1:0]   r_rem;
  logic [NUM_W-1:0]   r_dsr;
  logic [Z_W-2:0]     r_quo;
  logic [CNT_W-1:0]   r_cnt;

  // Output registers
  logic               r_out_valid;
  logic [COORD_W-1:0] r_out_x, r_out_y;
  logic [Z_W-1:0]     r_out_z;
  logic               r_done;

  // Control strobes from the next-state process
  logic w_accept;
  logic w_finish;
  logic w_advance;
  logic w_load_div;
  logic w_div_step;
  logic w_emit_ack;

  // Doubled unsigned triangle area via the signed shoelace formula.
  function automatic logic [AREA_W-1:0] f_area2(
    input logic [COORD_W-1:0] ax,
    input logic [COORD_W-1:0] ay,
    input logic [COORD_W-1:0] bx,
    input logic [COORD_W-1:0] by,
    input logic [COORD_W-1:0] cx,
    input logic [COORD_W-1:0] cy
  );
    logic signed [S_W-1:0] sax, say, sbx, sby, scx, scy;
    logic signed [S_W-1:0] s;
    sax = $signed({{(S_W-COORD_W){1'b0}}, ax});
    say = $signed({{(S_W-COORD_W){1'b0}}, ay});
    sbx = $signed({{(S_W-COORD_W){1'b0}}, bx});
    sby = $signed({{(S_W-COORD_W){1'b0}}, by});
    scx = $signed({{(S_W-COORD_W){1'b0}}, cx});
    scy = $signed({{(S_W-COORD_W){1'b0}}, cy});
    s = sax*sby + sbx*scy + scx*say - sbx*say - scx*sby - sax*scy;
    if (s < 0) begin
      s = -s;
    end
    return s[AREA_W-1:0];
  endfunction

  function automatic logic [COORD_W-1:0] f_min3(
    input logic [COORD_W-1:0] a,
    input logic [COORD_W-1:0] b,
    input logic [COORD_W-1:0] c
  );
    logic [COORD_W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [COORD_W-1:0] f_max3(
    input logic [COORD_W-1:0] a,
    input logic [COORD_W-1:0] b,
    input logic [COORD_W-1:0] c
  );
    logic [COORD_W-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // Combinational datapath
  logic [AREA_W-1:0]  w_a_tri;
  logic [AREA_W-1:0]  w_a1, w_a2, w_a3;
  logic [SUM_W-1:0]   w_sum;
  logic               w_inside;
  logic [NUM_W-1:0]   w_num;
  logic [COORD_W-1:0] w_xmin, w_xmax, w_ymin, w_ymax;
  logic               w_last;
  logic               w_div_last;
  logic               w_qbit;

  assign w_a_tri = f_area2(r_px, r_py, r_qx, r_qy, r_rx, r_ry);
  // Each sub-area is the weight of the vertex it excludes.
  assign w_a1    = f_area2(r_cx, r_cy, r_qx, r_qy, r_rx, r_ry);
  assign w_a2    = f_area2(r_px, r_py, r_cx, r_cy, r_rx, r_ry);
  assign w_a3    = f_area2(r_px, r_py, r_qx, r_qy, r_cx, r_cy);
  assign w_sum   = SUM_W'(w_a1) + SUM_W'(w_a2) + SUM_W'(w_a3);
  // Outside pixels make the sub-areas overshoot the triangle area.
  assign w_inside = (w_sum == SUM_W'(r_area));
  assign w_num   = NUM_W'(r_pz) * NUM_W'(w_a1)
                 + NUM_W'(r_qz) * NUM_W'(w_a2)
                 + NUM_W'(r_rz) * NUM_W'(w_a3);

  assign w_xmin = f_min3(r_px, r_qx, r_rx);
  assign w_xmax = f_max3(r_px, r_qx, r_rx);
  assign w_ymin = f_min3(r_py, r_qy, r_ry);
  assign w_ymax = f_max3(r_py, r_qy, r_ry);

  assign w_last     = (r_cx == r_xmax) && (r_cy == r_ymax);
  assign w_div_last = (r_cnt == CNT_W'(Z_W-1));
  assign w_qbit     = (r_rem >= r_dsr);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and control
  always_comb begin
    w_next     = r_state;
    tri_ready  = 1'b0;
    busy       = 1'b1;
    w_accept   = 1'b0;
    w_finish   = 1'b0;
    w_advance  = 1'b0;
    w_load_div = 1'b0;
    w_div_step = 1'b0;
    w_emit_ack = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        // The done pulse is presented in IDLE; hold off new work for that cycle.
        tri_ready = !r_done;
        if (tri_valid && !r_done) begin
          w_accept = 1'b1;
          w_next   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_a_tri == '0) begin
          w_finish = 1'b1;
          w_next   = S_IDLE;
        end else begin
          w_next = S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_inside) begin
          w_load_div = 1'b1;
          w_next     = S_DIVIDE;
        end else if (w_last) begin
          w_finish = 1'b1;
          w_next   = S_IDLE;
        end else begin
          w_advance = 1'b1;
        end
      end
      S_DIVIDE: begin
        w_div_step = 1'b1;
        if (w_div_last) begin
          w_next = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          w_emit_ack = 1'b1;
          if (w_last) begin
            w_finish = 1'b1;
            w_next   = S_IDLE;
          end else begin
            w_advance = 1'b1;
            w_next    = S_SCAN;
          end
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_px        <= '0;
      r_py        <= '0;
      r_qx        <= '0;
      r_qy        <= '0;
      r_rx        <= '0;
      r_ry        <= '0;
      r_pz        <= '0;
      r_qz        <= '0;
      r_rz        <= '0;
      r_area      <= '0;
      r_xmin      <= '0;
      r_xmax      <= '0;
      r_ymin      <= '0;
      r_ymax      <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_rem       <= '0;
      r_dsr       <= '0;
      r_quo       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_out_z     <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_finish;

      if (w_accept) begin
        r_px <= px;
        r_py <= py;
        r_qx <= qx;
        r_qy <= qy;
        r_rx <= rx;
        r_ry <= ry;
        r_pz <= pz;
        r_qz <= qz;
        r_rz <= rz;
      end

      if (r_state == S_SETUP) begin
        r_area <= w_a_tri;
        r_xmin <= w_xmin;
        r_xmax <= w_xmax;
        r_ymin <= w_ymin;
        r_ymax <= w_ymax;
        r_cx   <= w_xmin;
        r_cy   <= w_ymin;
      end

      if (w_advance) begin
        if (r_cx < r_xmax) begin
          r_cx <= r_cx + COORD_W'(1);
        end else begin
          r_cx <= r_xmin;
          r_cy <= r_cy + COORD_W'(1);
        end
      end

      // Divisor starts at A aligned to the quotient MSB and walks right one
      // place per cycle; num < 2^Z_W * A keeps the quotient within Z_W bits.
      if (w_load_div) begin
        r_rem <= w_num;
        r_dsr <= NUM_W'(r_area) << (Z_W-1);
        r_quo <= '0;
        r_cnt <= '0;
      end

      if (w_div_step) begin
        if (w_qbit) begin
          r_rem <= r_rem - r_dsr;
        end
        r_dsr <= r_dsr >> 1;
        r_quo <= (Z_W-1)'({r_quo, w_qbit});
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_div_last) begin
          r_out_valid <= 1'b1;
          r_out_x     <= r_cx;
          r_out_y     <= r_cy;
          r_out_z     <= {r_quo, w_qbit};
        end
      end

      if (w_emit_ack) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_x     = r_out_x;
  assign out_y     = r_out_y;
  assign out_z     = r_out_z;
  assign done      = r_done;

endmodule
